// File: rtl/dmb_dav_pkg.sv
// Shared definitions for the L1A/DAV queue write side.
// Holds the DAVACT word layout, the window FSM state type, the word packer
// and the majority voter used when the window FSM and queue pointers are
// triplicated.
package dmb_dav_pkg;

    localparam int DAV_W      = 7;
    localparam int DAVACT_W   = 17;
    localparam int DAV_LSB    = 0;
    localparam int DAV_MSB    = 6;
    localparam int OVL_BIT    = 7;
    localparam int TAG_LSB    = 8;
    localparam int TAG_MSB    = 15;
    localparam int NODATA_BIT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_CLOSE = 2'd2
    } win_state_t;

    // Bitwise 2-of-3 vote; callers cast their operands to and from 32 bits.
    function automatic logic [31:0] maj3(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Assemble one DAVACT word from its fields.
    function automatic logic [DAVACT_W-1:0] make_word(input logic             nodata,
                                                      input logic [7:0]       tag,
                                                      input logic             ovl,
                                                      input logic [DAV_W-1:0] dav);
        logic [DAVACT_W-1:0] w;
        w                  = '0;
        w[DAV_MSB:DAV_LSB] = dav;
        w[OVL_BIT]         = ovl;
        w[TAG_MSB:TAG_LSB] = tag;
        w[NODATA_BIT]      = nodata;
        return w;
    endfunction

endpackage

// File: rtl/dav_sync_fifo.sv
// First-word-fall-through synchronous queue for DAVACT words.
// Ports:
//   CLKCMS    clock, rising edge
//   RST       asynchronous active-high reset
//   srst      synchronous clear (pointers, flags, head word)
//   wr_en     push wr_data; ignored when full unless a pop happens in the same cycle
//   rd_en     pop; ignored when empty
//   rd_data   registered head word, holds its last value while empty
//   not_empty registered, 1 = rd_data valid
//   full      registered, queue holds DEPTH words
// Pointers carry one extra wrap bit; with TMR != 0 each pointer is kept in
// three copies that are rewritten every cycle from the voted value.
module dav_sync_fifo
    import dmb_dav_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16,
    parameter int TMR   = 0
) (
    input  logic             CLKCMS,
    input  logic             RST,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             not_empty,
    output logic             full
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int NREP = (TMR != 0) ? 3 : 1;
    localparam int R1   = (TMR != 0) ? 1 : 0;
    localparam int R2   = (TMR != 0) ? 2 : 0;

    logic [PW-1:0]    wr_ptr_r [NREP];
    logic [PW-1:0]    rd_ptr_r [NREP];
    logic [WIDTH-1:0] mem_r    [DEPTH];
    logic [WIDTH-1:0] rd_data_r;
    logic             not_empty_r;
    logic             full_r;

    logic [PW-1:0]    wr_ptr_s, rd_ptr_s, wr_nx_s, rd_nx_s;
    logic             do_wr_s, do_rd_s;
    logic [WIDTH-1:0] head_s;

    // Pointer voting, accepted read/write and next head word
    always_comb begin
        wr_ptr_s = PW'(maj3(32'(wr_ptr_r[0]), 32'(wr_ptr_r[R1]), 32'(wr_ptr_r[R2])));
        rd_ptr_s = PW'(maj3(32'(rd_ptr_r[0]), 32'(rd_ptr_r[R1]), 32'(rd_ptr_r[R2])));
        do_rd_s  = rd_en & not_empty_r;
        // A push into a full queue still lands when a pop frees a slot this cycle.
        do_wr_s  = wr_en & (~full_r | do_rd_s);
        wr_nx_s  = wr_ptr_s + PW'(do_wr_s);
        rd_nx_s  = rd_ptr_s + PW'(do_rd_s);
        // Bypass covers the word being written into the slot that becomes the head.
        head_s   = (do_wr_s && (wr_ptr_s[AW-1:0] == rd_nx_s[AW-1:0]))
                   ? wr_data : mem_r[rd_nx_s[AW-1:0]];
    end

    // Storage array write port
    always_ff @(posedge CLKCMS) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_s[AW-1:0]] <= wr_data;
        end
    end

    // Pointer copies, registered flags and head word
    always_ff @(posedge CLKCMS or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREP; i++) begin wr_ptr_r[i] <= '0; rd_ptr_r[i] <= '0; end
            not_empty_r <= 1'b0;
            full_r      <= 1'b0;
            rd_data_r   <= '0;
        end else if (srst) begin
            for (int i = 0; i < NREP; i++) begin wr_ptr_r[i] <= '0; rd_ptr_r[i] <= '0; end
            not_empty_r <= 1'b0;
            full_r      <= 1'b0;
            rd_data_r   <= '0;
        end else begin
            for (int i = 0; i < NREP; i++) begin wr_ptr_r[i] <= wr_nx_s; rd_ptr_r[i] <= rd_nx_s; end
            not_empty_r <= (wr_nx_s != rd_nx_s);
            full_r      <= (wr_nx_s[AW] != rd_nx_s[AW]) && (wr_nx_s[AW-1:0] == rd_nx_s[AW-1:0]);
            if (wr_nx_s != rd_nx_s) begin
                rd_data_r <= head_s;
            end
        end
    end

    assign rd_data   = rd_data_r;
    assign not_empty = not_empty_r;
    assign full      = full_r;

endmodule

// File: rtl/l1a_dav_fifo_writer.sv
// Write side of the L1A/DAV queue read by the DMB readout controller.
// Each L1A opens a WIN-cycle window that ORs in enabled DAV pulses; at the
// close (or when a new L1A overlaps the window) one DAVACT word is pushed.
// Ports:
//   CLKCMS   40 MHz clock, rising edge
//   RST      asynchronous active-high reset
//   L1ARST   synchronous clear of counter, queue, window and OVFL
//   L1A      one-cycle level-1 accept
//   DAVIN    [7:1] DAV pulses (1-5 CFEB, 6 TMB, 7 ALCT); DAVENBL masks them
//   POPBRAM  reader pop, honoured only while GEMPTY_B = 1
//   GEMPTY_B queue not empty; DAVACT valid
//   DAVACT   head word {nodata, tag[7:0], overlap, dav[6:0]}
//   QFULL    queue holds DEPTH words
//   OVFL     sticky, a push was dropped on a full queue
//   L1ACNT   24-bit L1A count
module l1a_dav_fifo_writer
    import dmb_dav_pkg::*;
#(
    parameter int WIN   = 16,
    parameter int DEPTH = 16,
    parameter int TMR   = 0
) (
    input  logic                CLKCMS,
    input  logic                RST,
    input  logic                L1ARST,
    input  logic                L1A,
    input  logic [7:1]          DAVIN,
    input  logic [7:1]          DAVENBL,
    input  logic                POPBRAM,
    output logic                GEMPTY_B,
    output logic [DAVACT_W-1:0] DAVACT,
    output logic                QFULL,
    output logic                OVFL,
    output logic [23:0]         L1ACNT
);
    localparam int         NREP   = (TMR != 0) ? 3 : 1;
    localparam int         R1     = (TMR != 0) ? 1 : 0;
    localparam int         R2     = (TMR != 0) ? 2 : 0;
    // The window spans timer values 0..WIN-1; the push is requested on the
    // edge where the timer steps onto WIN-1 so the word lands one edge later.
    localparam logic [7:0] T_LAST = 8'(WIN - 2);
    localparam logic [7:0] T_END  = 8'(WIN - 1);

    win_state_t          st_r    [NREP];
    logic [7:0]          timer_r [NREP];
    logic [DAV_W-1:0]    acc_r;
    logic [7:0]          tag_r;
    logic [23:0]         cnt_r;
    logic                push_r;
    logic [DAVACT_W-1:0] word_r;
    logic                ovfl_r;

    win_state_t          st_s;
    logic [7:0]          timer_s;
    logic [DAV_W-1:0]    dav_s, acc_nx_s;
    logic                fifo_ne_s, fifo_full_s;

    // FSM voting and qualified DAV for this cycle
    always_comb begin
        st_s     = win_state_t'(2'(maj3(32'(st_r[0]), 32'(st_r[R1]), 32'(st_r[R2]))));
        timer_s  = 8'(maj3(32'(timer_r[0]), 32'(timer_r[R1]), 32'(timer_r[R2])));
        dav_s    = DAVIN & DAVENBL;
        acc_nx_s = acc_r | dav_s;
    end

    // Window FSM, L1A counter, accumulator, push request and overflow flag
    always_ff @(posedge CLKCMS or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREP; i++) begin st_r[i] <= ST_IDLE; timer_r[i] <= 8'd0; end
            acc_r  <= '0;
            tag_r  <= 8'd0;
            cnt_r  <= 24'd0;
            push_r <= 1'b0;
            word_r <= '0;
            ovfl_r <= 1'b0;
        end else if (L1ARST) begin
            // Discards any open window and any push still in flight.
            for (int i = 0; i < NREP; i++) begin st_r[i] <= ST_IDLE; timer_r[i] <= 8'd0; end
            acc_r  <= '0;
            tag_r  <= 8'd0;
            cnt_r  <= 24'd0;
            push_r <= 1'b0;
            word_r <= '0;
            ovfl_r <= 1'b0;
        end else begin
            push_r <= 1'b0;
            ovfl_r <= ovfl_r | (push_r & fifo_full_s & ~(POPBRAM & fifo_ne_s));
            if (L1A) begin
                cnt_r <= cnt_r + 24'd1;
            end
            case (st_s)
                ST_OPEN: begin
                    if (L1A) begin
                        // Overlap: flush what was gathered so far, restart on the new L1A.
                        push_r <= 1'b1;
                        word_r <= make_word(acc_r == '0, tag_r, 1'b1, acc_r);
                        for (int i = 0; i < NREP; i++) begin st_r[i] <= ST_OPEN; timer_r[i] <= 8'd0; end
                        acc_r  <= dav_s;
                        tag_r  <= cnt_r[7:0];
                    end else if (timer_s == T_LAST) begin
                        push_r <= 1'b1;
                        word_r <= make_word(acc_nx_s == '0, tag_r, 1'b0, acc_nx_s);
                        for (int i = 0; i < NREP; i++) begin st_r[i] <= ST_CLOSE; timer_r[i] <= T_END; end
                        acc_r  <= acc_nx_s;
                    end else begin
                        for (int i = 0; i < NREP; i++) begin st_r[i] <= ST_OPEN; timer_r[i] <= timer_s + 8'd1; end
                        acc_r  <= acc_nx_s;
                    end
                end
                ST_IDLE, ST_CLOSE: begin
                    if (L1A) begin
                        for (int i = 0; i < NREP; i++) begin st_r[i] <= ST_OPEN; timer_r[i] <= 8'd0; end
                        acc_r <= dav_s;
                        tag_r <= cnt_r[7:0];
                    end else begin
                        for (int i = 0; i < NREP; i++) begin st_r[i] <= ST_IDLE; timer_r[i] <= 8'd0; end
                    end
                end
                default: begin
                    for (int i = 0; i < NREP; i++) begin st_r[i] <= ST_IDLE; timer_r[i] <= 8'd0; end
                end
            endcase
        end
    end

    dav_sync_fifo #(
        .WIDTH (DAVACT_W),
        .DEPTH (DEPTH),
        .TMR   (TMR)
    ) u_fifo (
        .CLKCMS    (CLKCMS),
        .RST       (RST),
        .srst      (L1ARST),
        .wr_en     (push_r),
        .wr_data   (word_r),
        .rd_en     (POPBRAM),
        .rd_data   (DAVACT),
        .not_empty (fifo_ne_s),
        .full      (fifo_full_s)
    );

    assign GEMPTY_B = fifo_ne_s;
    assign QFULL    = fifo_full_s;
    assign OVFL     = ovfl_r;
    assign L1ACNT   = cnt_r;

endmodule

// File: tb/tb_l1a_dav_fifo_writer.sv
// Directed bench for l1a_dav_fifo_writer (WIN=16, DEPTH=4, triplicated).
module tb_l1a_dav_fifo_writer;

    logic        CLKCMS, RST, L1ARST, L1A, POPBRAM;
    logic [7:1]  DAVIN, DAVENBL;
    logic        GEMPTY_B, QFULL, OVFL;
    logic [16:0] DAVACT;
    logic [23:0] L1ACNT;

    int tests;
    int fails;

    typedef struct {
        int          dav_off;   // cycle offset from the L1A cycle; 99 = none
        logic [6:0]  davin;
        logic [6:0]  enbl;
        logic [16:0] exp_word;
    } win_vec_t;

    win_vec_t vecs [7];

    l1a_dav_fifo_writer #(.WIN(16), .DEPTH(4), .TMR(1)) dut (
        .CLKCMS   (CLKCMS),
        .RST      (RST),
        .L1ARST   (L1ARST),
        .L1A      (L1A),
        .DAVIN    (DAVIN),
        .DAVENBL  (DAVENBL),
        .POPBRAM  (POPBRAM),
        .GEMPTY_B (GEMPTY_B),
        .DAVACT   (DAVACT),
        .QFULL    (QFULL),
        .OVFL     (OVFL),
        .L1ACNT   (L1ACNT)
    );

    initial CLKCMS = 1'b0;
    always #5 CLKCMS = ~CLKCMS;

    task automatic tick();
        @(posedge CLKCMS);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic l1arst_pulse();
        L1ARST = 1'b1;
        tick();
        L1ARST = 1'b0;
    endtask

    // L1A with no DAV; returns once the word is visible.
    task automatic empty_window();
        L1A = 1'b1;
        tick();
        L1A = 1'b0;
        repeat (16) tick();
    endtask

    initial begin
        tests = 0; fails = 0;
        RST = 1'b1; L1ARST = 1'b0; L1A = 1'b0; POPBRAM = 1'b0;
        DAVIN = 7'h00; DAVENBL = 7'h7F;
        repeat (3) tick();
        RST = 1'b0;
        tick();

        check("rst_gempty", 32'(GEMPTY_B), 32'd0);
        check("rst_davact", 32'(DAVACT), 32'h0);
        check("rst_qfull",  32'(QFULL), 32'd0);
        check("rst_ovfl",   32'(OVFL), 32'd0);
        check("rst_l1acnt", 32'(L1ACNT), 32'd0);

        // Single windows; tags run 0..6
        vecs[0] = '{3,  7'h02, 7'h7F, 17'h00002};
        vecs[1] = '{99, 7'h00, 7'h7F, 17'h10100};
        vecs[2] = '{0,  7'h7F, 7'h7E, 17'h0027E};
        vecs[3] = '{15, 7'h40, 7'h7F, 17'h00340};
        vecs[4] = '{16, 7'h7F, 7'h7F, 17'h10400};
        vecs[5] = '{8,  7'h7F, 7'h00, 17'h10500};
        vecs[6] = '{1,  7'h55, 7'h7F, 17'h00655};

        for (int i = 0; i < 7; i++) begin
            DAVENBL = vecs[i].enbl;
            L1A     = 1'b1;
            DAVIN   = (vecs[i].dav_off == 0) ? vecs[i].davin : 7'h00;
            tick();
            L1A = 1'b0;
            for (int c = 1; c <= 16; c++) begin
                DAVIN = (c == vecs[i].dav_off) ? vecs[i].davin : 7'h00;
                tick();
                if (c == 15) check($sformatf("v%0d_early", i), 32'(GEMPTY_B), 32'd0);
            end
            DAVIN = 7'h00;
            check($sformatf("v%0d_gempty", i), 32'(GEMPTY_B), 32'd1);
            check($sformatf("v%0d_word", i), 32'(DAVACT), 32'(vecs[i].exp_word));
            POPBRAM = 1'b1;
            tick();
            POPBRAM = 1'b0;
            check($sformatf("v%0d_popped", i), 32'(GEMPTY_B), 32'd0);
            check($sformatf("v%0d_hold", i), 32'(DAVACT), 32'(vecs[i].exp_word));
        end
        DAVENBL = 7'h7F;
        check("table_l1acnt", 32'(L1ACNT), 32'd7);

        // Overlapping L1A
        l1arst_pulse();
        L1A = 1'b1; tick(); L1A = 1'b0;          // t0
        tick();                                  // t0+1
        DAVIN = 7'h01; tick(); DAVIN = 7'h00;    // t0+2
        tick(); tick();                          // t0+3, t0+4
        L1A = 1'b1; tick(); L1A = 1'b0;          // t0+5
        check("ovl_not_yet", 32'(GEMPTY_B), 32'd0);
        tick();                                  // t0+6
        check("ovl_gempty", 32'(GEMPTY_B), 32'd1);
        check("ovl_word",   32'(DAVACT), 32'h00081);
        repeat (15) tick();                      // through t0+21
        check("ovl_l1acnt", 32'(L1ACNT), 32'd2);
        POPBRAM = 1'b1; tick(); POPBRAM = 1'b0;
        check("ovl_second", 32'(DAVACT), 32'h10100);
        check("ovl_second_v", 32'(GEMPTY_B), 32'd1);
        POPBRAM = 1'b1; tick(); POPBRAM = 1'b0;
        check("ovl_drained", 32'(GEMPTY_B), 32'd0);

        // Fill past DEPTH with no pops
        l1arst_pulse();
        for (int k = 0; k < 5; k++) begin
            empty_window();
            if (k == 2) check("fill_notfull", 32'(QFULL), 32'd0);
            if (k == 3) check("fill_full", 32'(QFULL), 32'd1);
            if (k == 3) check("fill_noovfl", 32'(OVFL), 32'd0);
            if (k == 4) check("fill_ovfl", 32'(OVFL), 32'd1);
            if (k == 4) check("fill_stillfull", 32'(QFULL), 32'd1);
        end
        for (int j = 0; j < 4; j++) begin
            check($sformatf("drain%0d_word", j), 32'(DAVACT), 32'h10000 + 32'(j) * 32'h100);
            POPBRAM = 1'b1; tick(); POPBRAM = 1'b0;
        end
        check("drain_empty", 32'(GEMPTY_B), 32'd0);
        check("drain_ovfl_sticky", 32'(OVFL), 32'd1);

        // Push and pop together while full
        l1arst_pulse();
        check("clr_ovfl",   32'(OVFL), 32'd0);
        check("clr_davact", 32'(DAVACT), 32'h0);
        repeat (4) empty_window();
        check("pp_full", 32'(QFULL), 32'd1);
        L1A = 1'b1; tick(); L1A = 1'b0;
        repeat (15) tick();
        POPBRAM = 1'b1; tick(); POPBRAM = 1'b0;  // pop lands on the push edge
        check("pp_qfull", 32'(QFULL), 32'd1);
        check("pp_ovfl",  32'(OVFL), 32'd0);
        check("pp_head",  32'(DAVACT), 32'h10100);
        repeat (3) begin POPBRAM = 1'b1; tick(); POPBRAM = 1'b0; end
        check("pp_newest", 32'(DAVACT), 32'h10400);

        // L1ARST mid-window, with a coincident L1A that must be ignored
        L1A = 1'b1; tick(); L1A = 1'b0;
        repeat (5) tick();
        L1ARST = 1'b1; L1A = 1'b1;
        tick();
        L1ARST = 1'b0; L1A = 1'b0;
        repeat (20) tick();
        check("mid_gempty", 32'(GEMPTY_B), 32'd0);
        check("mid_l1acnt", 32'(L1ACNT), 32'd0);
        check("mid_davact", 32'(DAVACT), 32'h0);
        check("mid_qfull",  32'(QFULL), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
